// File: rtl/hello_tx.sv
// "Hello" byte-stream transmitter: sends "Hello" a latched number of times over a
// valid/ready link, with optional inter-byte gaps, sticky abort and busy/done status.
module hello_tx #(
    parameter int unsigned GAP   = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned   GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] rep_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [2:0]       idx_q;
    logic [GW-1:0]    gap_q;
    logic             abort_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             handshake;
    logic             word_end;
    logic             last_word;
    logic             abort_seen;
    logic [2:0]       idx_nxt;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [7:0] hello_char(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h48;
            3'd1:    return 8'h65;
            3'd2:    return 8'h6C;
            3'd3:    return 8'h6C;
            default: return 8'h6F;
        endcase
    endfunction

    always_comb begin
        handshake  = tx_valid_q & tx_ready;
        word_end   = (idx_q == 3'd4);
        cnt_inc    = word_cnt_q + CNT_W'(1);
        idx_nxt    = word_end ? 3'd0 : idx_q + 3'd1;
        last_word  = word_end && (cnt_inc == rep_q);
        // An abort raised on the handshake edge itself already ends the run there.
        abort_seen = abort_q | abort;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rep_q      <= '0;
            word_cnt_q <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            abort_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && abort) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        word_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        abort_q    <= 1'b0;
                        if (rep != '0) begin
                            rep_q      <= rep;
                            idx_q      <= '0;
                            tx_data_q  <= hello_char(3'd0);
                            tx_valid_q <= 1'b1;
                            state_q    <= S_SEND;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        idx_q <= idx_nxt;
                        if (word_end) begin
                            word_cnt_q <= cnt_inc;
                        end
                        if (last_word || abort_seen) begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_FIN;
                        end else if (GAP > 0) begin
                            tx_valid_q <= 1'b0;
                            gap_q      <= '0;
                            state_q    <= S_GAP;
                        end else begin
                            tx_data_q <= hello_char(idx_nxt);
                        end
                    end
                end
                S_GAP: begin
                    if (abort_seen) begin
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else if (gap_q == GAP_LAST) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= hello_char(idx_q);
                        state_q    <= S_SEND;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    abort_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_hello_tx.sv
// Directed bench for hello_tx: one instance without gaps, one with GAP=2.
module tb_hello_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start2, abort, ready;
    logic [7:0] rep;

    logic [7:0] data0, data2, wc0, wc2;
    logic       valid0, valid2, busy0, busy2, done0, done2;

    int checks = 0;
    int errors = 0;

    logic [7:0] hello [5];

    always #5 clk = ~clk;

    hello_tx #(.GAP(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .rep(rep), .abort(abort),
        .tx_data(data0), .tx_valid(valid0), .tx_ready(ready),
        .busy(busy0), .done(done0), .word_cnt(wc0)
    );

    hello_tx #(.GAP(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .rep(rep), .abort(abort),
        .tx_data(data2), .tx_valid(valid2), .tx_ready(ready),
        .busy(busy2), .done(done2), .word_cnt(wc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int   nbytes;
        logic stall;
        logic done_seen;
        logic [7:0] prev_data;

        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F;

        rst = 1'b0; start0 = 1'b0; start2 = 1'b0; abort = 1'b0; ready = 1'b1; rep = 8'd0;
        tick();
        chk("rst_data", data0, 8'h00);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_wc", wc0, 8'd0);
        rst = 1'b1;
        tick();

        // Basic run, GAP=0, rep=1
        rep = 8'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("basic_valid", valid0, 1'b1);
            chk("basic_data", data0, hello[i]);
            chk("basic_busy", busy0, 1'b1);
            tick();
        end
        chk("basic_done", done0, 1'b1);
        chk("basic_fin_valid", valid0, 1'b0);
        chk("basic_fin_busy", busy0, 1'b1);
        chk("basic_wc", wc0, 8'd1);
        tick();
        chk("basic_done_off", done0, 1'b0);
        chk("basic_busy_off", busy0, 1'b0);
        chk("basic_wc_hold", wc0, 8'd1);

        // Repeat with gap, GAP=2, rep=3
        rep = 8'd3; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        rep = 8'd9;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 5; i++) begin
                chk("gap_valid", valid2, 1'b1);
                chk("gap_data", data2, hello[i]);
                chk("gap_nodone", done2, 1'b0);
                tick();
                if (!(w == 2 && i == 4)) begin
                    for (int g = 0; g < 2; g++) begin
                        chk("gap_idle", valid2, 1'b0);
                        chk("gap_busy", busy2, 1'b1);
                        chk("gap_wc", wc2, (i == 4) ? w + 1 : w);
                        tick();
                    end
                end
            end
        end
        chk("gap_done", done2, 1'b1);
        chk("gap_wc_final", wc2, 8'd3);
        tick();
        chk("gap_done_off", done2, 1'b0);
        chk("gap_busy_off", busy2, 1'b0);

        // Backpressure, rep=2, random ready
        rep = 8'd2; start0 = 1'b1; ready = 1'b0;
        tick();
        start0 = 1'b0;
        nbytes = 0; stall = 1'b0; done_seen = 1'b0; prev_data = 8'h00;
        for (int c = 0; c < 300; c++) begin
            if (stall) begin
                chk("bp_hold_valid", valid0, 1'b1);
                chk("bp_hold_data", data0, prev_data);
            end
            if (done0) begin
                done_seen = 1'b1;
                break;
            end
            ready = 1'($urandom_range(0, 1));
            if (valid0 && ready) begin
                chk("bp_byte", data0, hello[nbytes % 5]);
                nbytes++;
                stall = 1'b0;
            end else begin
                stall = valid0;
            end
            prev_data = data0;
            tick();
        end
        chk("bp_done_seen", done_seen, 1'b1);
        chk("bp_nbytes", nbytes, 10);
        chk("bp_wc", wc0, 8'd2);
        ready = 1'b1;
        tick();
        chk("bp_busy_off", busy0, 1'b0);

        // Abort during 3rd byte of word 2, rep=5
        rep = 8'd5; start0 = 1'b1; ready = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            chk("ab_data", data0, hello[k % 5]);
            tick();
        end
        chk("ab_offer", data0, 8'h6C);
        ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_hold_valid", valid0, 1'b1);
        chk("ab_hold_data", data0, 8'h6C);
        ready = 1'b1;
        tick();
        chk("ab_done", done0, 1'b1);
        chk("ab_valid_off", valid0, 1'b0);
        chk("ab_wc", wc0, 8'd1);
        tick();
        chk("ab_busy_off", busy0, 1'b0);
        chk("ab_no_more", valid0, 1'b0);
        chk("ab_wc_hold", wc0, 8'd1);

        // rep=0: immediate done, nothing sent
        rep = 8'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("r0_done", done0, 1'b1);
        chk("r0_valid", valid0, 1'b0);
        chk("r0_wc", wc0, 8'd0);
        chk("r0_busy", busy0, 1'b1);
        tick();
        chk("r0_done_off", done0, 1'b0);
        chk("r0_busy_off", busy0, 1'b0);
        chk("r0_valid_off", valid0, 1'b0);

        // start held high through a run: restart only after busy=0
        rep = 8'd1; start0 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("hold_data", data0, hello[i]);
            tick();
        end
        chk("hold_done", done0, 1'b1);
        tick();
        chk("hold_idle_busy", busy0, 1'b0);
        chk("hold_idle_valid", valid0, 1'b0);
        tick();
        start0 = 1'b0;
        chk("hold_restart_valid", valid0, 1'b1);
        chk("hold_restart_data", data0, 8'h48);
        chk("hold_restart_busy", busy0, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("hold_end_busy", busy0, 1'b0);

        // Async reset during byte 3
        rep = 8'd2; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        chk("rr_byte3", data0, 8'h6C);
        #1 rst = 1'b0;
        #1;
        chk("rr_data", data0, 8'h00);
        chk("rr_valid", valid0, 1'b0);
        chk("rr_busy", busy0, 1'b0);
        chk("rr_done", done0, 1'b0);
        chk("rr_wc", wc0, 8'd0);
        tick();
        rst = 1'b1;
        chk("rr_no_done", done0, 1'b0);
        rep = 8'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("rr_first", data0, 8'h48);
        chk("rr_first_valid", valid0, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        chk("rr_end_busy", busy0, 1'b0);
        chk("rr_end_wc", wc0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hello_tx.md
# hello_tx

Transmitter for the "Hello" byte protocol: on a start request, emits the ASCII sequence "H","e","l","l","o" (0x48, 0x65, 0x6C, 0x6C, 0x6F) a programmable number of times over a valid/ready byte stream.
- Sits at the sending end of the link whose receiving end is the team's "Hello" sequence detector.
- Used to drive that detector in system tests and as a keep-alive source.
- Supports inter-byte gaps, repeat count, abort, and busy/done status.

## Interface
- GAP, 0: idle cycles (tx_valid low) inserted after every accepted byte, including after the last byte of a word.
- CNT_W, 8: width of repeat count and word counter.

- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to begin transmission; sampled only while busy=0.
- rep  in  CNT_W  number of "Hello" words to send; latched when start is accepted.
- abort  in  1  request to stop early; level-sampled each cycle while busy=1.
- tx_data  out  8  byte being offered.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts byte when high together with tx_valid at a rising edge.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse at end of transmission, whether complete or aborted.
- word_cnt  out  CNT_W  number of complete words transferred in the current or last transmission.

## Operation
- Reset values: tx_data=0x00, tx_valid=0, busy=0, done=0, word_cnt=0; FSM in IDLE; rep latch, byte index, gap counter and abort flag cleared.
- States:
  - IDLE: busy=0.
  - SEND: tx_valid=1, tx_data=char[idx].
  - GAP: tx_valid=0, counting GAP cycles.
  - FIN: done=1 for one cycle.
- IDLE -> SEND on start=1 with rep!=0:
  - latch rep, idx=0, word_cnt=0, busy=1.
- IDLE -> FIN on start=1 with rep=0:
  - no bytes sent; word_cnt=0.
- SEND, no handshake: hold tx_valid=1 and tx_data stable. tx_valid never drops before acceptance, even if abort is raised.
- SEND, handshake (tx_valid & tx_ready):
  - idx increments; after idx=4 it wraps to 0 and word_cnt increments.
  - If the word just completed makes word_cnt equal the latched rep, or the abort flag is set: go to FIN. Any GAP count is skipped.
  - Otherwise: go to GAP if GAP>0, else stay in SEND with the next byte.
- GAP: counts GAP cycles, then returns to SEND. If the abort flag is set, go to FIN immediately.
- Abort:
  - abort=1 while busy sets a sticky abort flag, cleared in FIN.
  - The flag takes effect at the next byte boundary: after the current byte's handshake, or immediately in GAP.
  - A partially sent word is not counted in word_cnt.
- FIN -> IDLE after one cycle: done=1, busy=1 in FIN; busy=0 the following cycle.
- start while busy=1, including the FIN cycle, is ignored and is not queued.
- word_cnt holds its final value after FIN until the next accepted start.
- rep changes after start acceptance have no effect.
- Async reset mid-transmission: all outputs go to their reset values immediately. No done pulse is generated.

## Timing
- Start latency: start high at edge N; tx_valid=1 with tx_data=0x48 after edge N, visible in cycle N+1.
- Throughput:
  - GAP=0 and tx_ready held high: one byte per cycle, 5 cycles per word.
  - Otherwise: (1+GAP) cycles per byte when ready is always high.
- Completion: last "o" accepted at edge M; the FSM is in FIN (done=1) during cycle M+1; busy=0 from cycle M+2.
- Earliest restart: start sampled at the edge ending the first busy=0 cycle.
- tx_data changes only after a handshake edge or when entering SEND. In GAP, tx_data keeps the last byte value and carries no meaning.
- Backpressure: arbitrarily long tx_ready=0 stalls are allowed. State and counters freeze during a stall.

## Test plan
- Basic run: GAP=0, rep=1, tx_ready=1, pulse start.
  - Required: bytes 48 65 6C 6C 6F on 5 consecutive cycles.
  - Required: done one cycle after the 6F handshake; word_cnt=1; busy low the cycle after done.
- Repeat with gap: GAP=2, rep=3, tx_ready=1.
  - Required: 15 bytes, each followed by exactly 2 tx_valid=0 cycles, except no gap after the final 6F.
  - Required: word_cnt steps 1, 2, 3; single done pulse.
- Backpressure: rep=2, tx_ready random 50%.
  - Required: tx_valid never drops and tx_data never changes without a handshake.
  - Required: byte stream is "HelloHello"; word_cnt=2.
- Abort mid-word: rep=5, GAP=0.
  - Stimulus: assert abort for 1 cycle while the 3rd byte of word 2 (6C) is offered with tx_ready=0, then raise tx_ready.
  - Required: that 6C is transferred and then no more bytes; done pulses; word_cnt=1.
- Edge cases:
  - rep=0 with start: done in the next cycle, no tx_valid, word_cnt=0.
  - start held high during a run: no restart until busy=0.
  - rst low during byte 3: all outputs 0 immediately; the next start sends from 0x48.
